// File: rtl/inst_split_seq_pkg.sv
// Shared definitions for the store-splitting sequencer: instruction width, store encodings
// and sequencer states.
`ifndef WIDTH_INST
`define WIDTH_INST 32
`endif

package inst_split_seq_pkg;

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [2:0] FUNCT3_SB    = 3'b000;
  localparam logic [2:0] FUNCT3_SH    = 3'b001;
  localparam logic [2:0] FUNCT3_LW    = 3'b010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PRE  = 1'b1
  } state_e;

  // Byte and halfword stores are expanded; sw and everything else pass through.
  function automatic logic is_split_store(input logic [`WIDTH_INST-1:0] inst);
    return (inst[6:0] == OPCODE_STORE) &&
           ((inst[14:12] == FUNCT3_SB) || (inst[14:12] == FUNCT3_SH));
  endfunction

endpackage

// File: rtl/inst_split_seq_divider.sv
// InstDivider: builds the lw x0, imm(rs1) prefix that shares the store's address.
`ifndef WIDTH_INST
`define WIDTH_INST 32
`endif

module inst_split_seq_divider
  import inst_split_seq_pkg::*;
(
  input  logic [`WIDTH_INST-1:0] inst_i,
  output logic [`WIDTH_INST-1:0] prefix_o
);

  logic [11:0] imm;
  logic        unused_bits;

  assign imm         = {inst_i[31:25], inst_i[11:7]};
  assign unused_bits = ^{inst_i[24:20], inst_i[14:12], inst_i[6:0]};
  assign prefix_o    = {imm, inst_i[19:15], FUNCT3_LW, 5'd0, OPCODE_LOAD};

endmodule

// File: rtl/inst_split_seq.sv
// Fetch-to-decode sequencer that issues sb/sh as a load prefix followed by the store.
// Optional split counter enabled by defining INST_SPLIT_CNT_EN.
`ifndef WIDTH_INST
`define WIDTH_INST 32
`endif

module inst_split_seq
  import inst_split_seq_pkg::*;
#(
  parameter int unsigned WIDTH_PC = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   fetch_valid,
  input  logic [`WIDTH_INST-1:0] fetch_inst,
  input  logic [WIDTH_PC-1:0]    fetch_pc,
  output logic                   fetch_ready,
  output logic                   dec_valid,
  output logic [`WIDTH_INST-1:0] dec_inst,
  output logic [WIDTH_PC-1:0]    dec_pc,
  output logic                   dec_is_prefix,
  input  logic                   dec_ready,
  output logic [31:0]            split_cnt
);

  state_e                 state_q, state_d;
  logic                   dec_valid_q, dec_valid_d;
  logic [`WIDTH_INST-1:0] dec_inst_q, dec_inst_d;
  logic [WIDTH_PC-1:0]    dec_pc_q, dec_pc_d;
  logic                   dec_is_prefix_q, dec_is_prefix_d;
  logic [`WIDTH_INST-1:0] held_inst_q, held_inst_d;
  logic [WIDTH_PC-1:0]    held_pc_q, held_pc_d;

  logic [`WIDTH_INST-1:0] prefix_inst;
  logic                   slot_free;
  logic                   accept;

  inst_split_seq_divider u_divider (
    .inst_i   (fetch_inst),
    .prefix_o (prefix_inst)
  );

  assign slot_free   = !dec_valid_q || dec_ready;
  assign fetch_ready = slot_free && (state_q != S_PRE) && !flush;
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    state_d         = state_q;
    dec_valid_d     = dec_valid_q;
    dec_inst_d      = dec_inst_q;
    dec_pc_d        = dec_pc_q;
    dec_is_prefix_d = dec_is_prefix_q;
    held_inst_d     = held_inst_q;
    held_pc_d       = held_pc_q;
    if (flush) begin
      state_d         = S_IDLE;
      dec_valid_d     = 1'b0;
      dec_is_prefix_d = 1'b0;
      held_inst_d     = '0;
      held_pc_d       = '0;
    end else if (state_q == S_PRE) begin
      // Slot stays valid: the held store replaces the consumed prefix.
      if (dec_ready) begin
        state_d         = S_IDLE;
        dec_inst_d      = held_inst_q;
        dec_pc_d        = held_pc_q;
        dec_is_prefix_d = 1'b0;
      end
    end else if (accept) begin
      dec_valid_d = 1'b1;
      dec_pc_d    = fetch_pc;
      if (is_split_store(fetch_inst)) begin
        state_d         = S_PRE;
        dec_inst_d      = prefix_inst;
        dec_is_prefix_d = 1'b1;
        held_inst_d     = fetch_inst;
        held_pc_d       = fetch_pc;
      end else begin
        dec_inst_d      = fetch_inst;
        dec_is_prefix_d = 1'b0;
      end
    end else if (dec_ready) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      dec_valid_q     <= 1'b0;
      dec_inst_q      <= '0;
      dec_pc_q        <= '0;
      dec_is_prefix_q <= 1'b0;
      held_inst_q     <= '0;
      held_pc_q       <= '0;
    end else begin
      state_q         <= state_d;
      dec_valid_q     <= dec_valid_d;
      dec_inst_q      <= dec_inst_d;
      dec_pc_q        <= dec_pc_d;
      dec_is_prefix_q <= dec_is_prefix_d;
      held_inst_q     <= held_inst_d;
      held_pc_q       <= held_pc_d;
    end
  end

  assign dec_valid     = dec_valid_q;
  assign dec_inst      = dec_inst_q;
  assign dec_pc        = dec_pc_q;
  assign dec_is_prefix = dec_is_prefix_q;

`ifdef INST_SPLIT_CNT_EN
  logic [31:0] split_cnt_q, split_cnt_d;

  always_comb begin
    split_cnt_d = split_cnt_q;
    if ((state_q == S_PRE) && dec_ready && !flush) begin
      split_cnt_d = split_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_cnt_q <= '0;
    end else begin
      split_cnt_q <= split_cnt_d;
    end
  end

  assign split_cnt = split_cnt_q;
`else
  assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_split_seq.sv
// Directed self-checking bench for inst_split_seq (split counter checked when
// INST_SPLIT_CNT_EN is defined, otherwise expected to read zero).
`ifndef WIDTH_INST
`define WIDTH_INST 32
`endif

module tb_inst_split_seq;

`ifdef INST_SPLIT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam logic [31:0] AddInst  = 32'h00B50533;
  localparam logic [31:0] SbInst   = 32'h005501A3;
  localparam logic [31:0] SbPre    = 32'h00352003;
  localparam logic [31:0] ShInst   = 32'h00659423;
  localparam logic [31:0] ShPre    = 32'h0085A003;
  localparam logic [31:0] SwInst   = 32'h005521A3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_is_prefix;
  logic        dec_ready;
  logic [31:0] split_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_split_seq #(.WIDTH_PC(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .fetch_valid   (fetch_valid),
    .fetch_inst    (fetch_inst),
    .fetch_pc      (fetch_pc),
    .fetch_ready   (fetch_ready),
    .dec_valid     (dec_valid),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .dec_is_prefix (dec_is_prefix),
    .dec_ready     (dec_ready),
    .split_cnt     (split_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0;
    dec_ready = 1'b0;
    step(); step();
    checks++; if (dec_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%0b exp=0", dec_valid); end
    checks++; if (dec_inst !== 32'h0) begin failures++;
      $display("FAIL reset_inst got=%h exp=0", dec_inst); end
    checks++; if (dec_pc !== 32'h0) begin failures++;
      $display("FAIL reset_pc got=%h exp=0", dec_pc); end
    checks++; if (dec_is_prefix !== 1'b0) begin failures++;
      $display("FAIL reset_prefix got=%0b exp=0", dec_is_prefix); end
    checks++; if (split_cnt !== 32'h0) begin failures++;
      $display("FAIL reset_cnt got=%0d exp=0", split_cnt); end
    rst = 1'b0;
    step();
    checks++; if (fetch_ready !== 1'b1) begin failures++;
      $display("FAIL reset_fetch_ready got=%0b exp=1", fetch_ready); end
  endtask

  task automatic test_plain();
    fetch_valid = 1'b1; fetch_inst = AddInst; fetch_pc = 32'h100; dec_ready = 1'b1;
    step();
    fetch_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== AddInst || dec_pc !== 32'h100) begin
      failures++;
      $display("FAIL plain_out got v=%0b i=%h pc=%h exp v=1 i=%h pc=100",
               dec_valid, dec_inst, dec_pc, AddInst); end
    checks++; if (dec_is_prefix !== 1'b0 || fetch_ready !== 1'b1) begin failures++;
      $display("FAIL plain_flags got pre=%0b fr=%0b exp pre=0 fr=1", dec_is_prefix, fetch_ready);
    end
    step();
    checks++; if (dec_valid !== 1'b0) begin failures++;
      $display("FAIL plain_drain got=%0b exp=0", dec_valid); end
  endtask

  task automatic test_split();
    fetch_valid = 1'b1; fetch_inst = SbInst; fetch_pc = 32'h200; dec_ready = 1'b1;
    step();
    fetch_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== SbPre || dec_pc !== 32'h200 ||
                  dec_is_prefix !== 1'b1) begin failures++;
      $display("FAIL split_prefix got v=%0b i=%h pc=%h pre=%0b exp v=1 i=%h pc=200 pre=1",
               dec_valid, dec_inst, dec_pc, dec_is_prefix, SbPre); end
    checks++; if (fetch_ready !== 1'b0) begin failures++;
      $display("FAIL split_fetch_stall got=%0b exp=0", fetch_ready); end
    step();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== SbInst || dec_pc !== 32'h200 ||
                  dec_is_prefix !== 1'b0) begin failures++;
      $display("FAIL split_store got v=%0b i=%h pc=%h pre=%0b exp v=1 i=%h pc=200 pre=0",
               dec_valid, dec_inst, dec_pc, dec_is_prefix, SbInst); end
    checks++; if (split_cnt !== (CntEn ? 32'd1 : 32'd0)) begin failures++;
      $display("FAIL split_cnt1 got=%0d exp=%0d", split_cnt, CntEn ? 1 : 0); end
    step();
    checks++; if (dec_valid !== 1'b0) begin failures++;
      $display("FAIL split_drain got=%0b exp=0", dec_valid); end
  endtask

  task automatic test_sw();
    fetch_valid = 1'b1; fetch_inst = SwInst; fetch_pc = 32'h300; dec_ready = 1'b1;
    step();
    fetch_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== SwInst || dec_is_prefix !== 1'b0) begin
      failures++;
      $display("FAIL sw_pass got v=%0b i=%h pre=%0b exp v=1 i=%h pre=0",
               dec_valid, dec_inst, dec_is_prefix, SwInst); end
    step();
    checks++; if (dec_valid !== 1'b0) begin failures++;
      $display("FAIL sw_single_slot got=%0b exp=0", dec_valid); end
  endtask

  task automatic test_backpressure();
    fetch_valid = 1'b1; fetch_inst = SbInst; fetch_pc = 32'h400; dec_ready = 1'b0;
    step();
    fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dec_valid !== 1'b1 || dec_inst !== SbPre || dec_is_prefix !== 1'b1 ||
                    fetch_ready !== 1'b0) begin failures++;
        $display("FAIL bp_hold[%0d] got v=%0b i=%h pre=%0b fr=%0b exp v=1 i=%h pre=1 fr=0",
                 i, dec_valid, dec_inst, dec_is_prefix, fetch_ready, SbPre); end
    end
    dec_ready = 1'b1;
    step();
    checks++; if (dec_inst !== SbInst || dec_pc !== 32'h400 || dec_is_prefix !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got i=%h pc=%h pre=%0b exp i=%h pc=400 pre=0",
               dec_inst, dec_pc, dec_is_prefix, SbInst); end
    checks++; if (split_cnt !== (CntEn ? 32'd2 : 32'd0)) begin failures++;
      $display("FAIL bp_cnt got=%0d exp=%0d", split_cnt, CntEn ? 2 : 0); end
    step();
  endtask

  task automatic test_back_to_back();
    fetch_valid = 1'b1; fetch_inst = SbInst; fetch_pc = 32'h500; dec_ready = 1'b1;
    step();
    fetch_inst = ShInst; fetch_pc = 32'h504;
    checks++; if (fetch_ready !== 1'b0 || dec_inst !== SbPre) begin failures++;
      $display("FAIL b2b_stall got fr=%0b i=%h exp fr=0 i=%h", fetch_ready, dec_inst, SbPre);
    end
    step();
    checks++; if (dec_inst !== SbInst || dec_pc !== 32'h500 || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_store1 got i=%h pc=%h fr=%0b exp i=%h pc=500 fr=1",
               dec_inst, dec_pc, fetch_ready, SbInst); end
    step();
    fetch_valid = 1'b0;
    checks++; if (dec_inst !== ShPre || dec_pc !== 32'h504 || dec_is_prefix !== 1'b1) begin
      failures++;
      $display("FAIL b2b_prefix2 got i=%h pc=%h pre=%0b exp i=%h pc=504 pre=1",
               dec_inst, dec_pc, dec_is_prefix, ShPre); end
    step();
    checks++; if (dec_inst !== ShInst || dec_is_prefix !== 1'b0 || dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_store2 got i=%h pre=%0b v=%0b exp i=%h pre=0 v=1",
               dec_inst, dec_is_prefix, dec_valid, ShInst); end
    checks++; if (split_cnt !== (CntEn ? 32'd4 : 32'd0)) begin failures++;
      $display("FAIL b2b_cnt got=%0d exp=%0d", split_cnt, CntEn ? 4 : 0); end
    step();
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1; fetch_inst = SbInst; fetch_pc = 32'h600; dec_ready = 1'b0;
    step();
    flush = 1'b1; fetch_inst = AddInst; fetch_pc = 32'h700;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin failures++;
      $display("FAIL flush_fetch_ready got=%0b exp=0", fetch_ready); end
    step();
    flush = 1'b0;
    checks++; if (dec_valid !== 1'b0 || dec_is_prefix !== 1'b0) begin failures++;
      $display("FAIL flush_clear got v=%0b pre=%0b exp v=0 pre=0", dec_valid, dec_is_prefix);
    end
    checks++; if (split_cnt !== (CntEn ? 32'd4 : 32'd0)) begin failures++;
      $display("FAIL flush_cnt got=%0d exp=%0d", split_cnt, CntEn ? 4 : 0); end
    dec_ready = 1'b1;
    step();
    fetch_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_inst !== AddInst || dec_pc !== 32'h700 ||
                  dec_is_prefix !== 1'b0) begin failures++;
      $display("FAIL flush_recover got v=%0b i=%h pc=%h pre=%0b exp v=1 i=%h pc=700 pre=0",
               dec_valid, dec_inst, dec_pc, dec_is_prefix, AddInst); end
    step();
    checks++; if (dec_valid !== 1'b0) begin failures++;
      $display("FAIL flush_no_store got v=%0b i=%h exp v=0", dec_valid, dec_inst); end
  endtask

  task automatic test_async_reset();
    fetch_valid = 1'b1; fetch_inst = SbInst; fetch_pc = 32'h800; dec_ready = 1'b1;
    step();
    fetch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (dec_valid !== 1'b0 || dec_inst !== 32'h0 || dec_pc !== 32'h0 ||
                  dec_is_prefix !== 1'b0 || split_cnt !== 32'h0) begin failures++;
      $display("FAIL async_rst got v=%0b i=%h pc=%h pre=%0b cnt=%0d exp all 0",
               dec_valid, dec_inst, dec_pc, dec_is_prefix, split_cnt); end
    step();
    #2 rst = 1'b0;
    step();
    checks++; if (dec_valid !== 1'b0 || fetch_ready !== 1'b1) begin failures++;
      $display("FAIL async_rst_idle got v=%0b fr=%0b exp v=0 fr=1", dec_valid, fetch_ready);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_split();
    test_sw();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
